// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load-op encoding, stage FSM states,
// and helpers that derive access size and signedness from a load op.
package wb_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    LWU = 3'd5,
    LD  = 3'd6
  } load_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_e;

  // log2 of the access size in bytes; LD collapses to a word on a 32-bit datapath.
  function automatic logic [1:0] load_size(input logic [2:0] op, input int data_w);
    logic [1:0] sz;
    case (load_op_e'(op))
      LB, LBU: sz = 2'd0;
      LH, LHU: sz = 2'd1;
      LD:      sz = (data_w == 64) ? 2'd3 : 2'd2;
      default: sz = 2'd2;
    endcase
    return sz;
  endfunction

  function automatic logic load_signed(input logic [2:0] op);
    return (op == LB) || (op == LH) || (op == LW);
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: shifts the SRAM word down to the addressed,
// size-aligned byte lane and sign- or zero-extends it to the full datapath.
module wb_load_align
  import wb_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BYTE_W = DATA_W / 8,
  localparam int OFS_W  = $clog2(BYTE_W)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFS_W-1:0]  addr_lo,
  input  logic [2:0]        load_op,
  output logic [DATA_W-1:0] data
);

  logic [1:0]        size;
  logic [OFS_W-1:0]  ofs;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic [6:0]        nbits;
  logic              msb;
  logic              fill;

  always_comb begin
    size    = load_size(load_op, DATA_W);
    // Misaligned low bits are dropped: the access is aligned down to its size.
    ofs     = addr_lo & ({OFS_W{1'b1}} << size);
    shifted = rdata >> {ofs, 3'b000};
    nbits   = 7'd8 << size;
    keep    = ~({DATA_W{1'b1}} << nbits);
    case (size)
      2'd0:    msb = shifted[7];
      2'd1:    msb = shifted[15];
      2'd2:    msb = shifted[31];
      default: msb = shifted[DATA_W-1];
    endcase
    fill = msb & load_signed(load_op);
    data = (shifted & keep) | ({DATA_W{fill}} & ~keep);
  end

endmodule

// File: rtl/wb_stage_gen.sv
// Parametrised pipeline writeback stage with load-response wait, bypass bus and
// retire counter. Optional commit trace ports are enabled by WB_TRACE_EN.
module wb_stage_gen
  import wb_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int RF_AW  = 5,
  parameter  int PC_W   = 32,
  parameter  int CNT_W  = 32,
  localparam int BYTE_W = DATA_W / 8,
  localparam int OFS_W  = $clog2(BYTE_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ms_to_ws_valid,
  output logic              ws_allow_in,
  input  logic [PC_W-1:0]   ms_pc,
  input  logic [BYTE_W-1:0] ms_rf_we,
  input  logic [RF_AW-1:0]  ms_rf_waddr,
  input  logic [DATA_W-1:0] ms_result,
  input  logic              ms_is_load,
  input  logic [2:0]        ms_load_op,
  input  logic [OFS_W-1:0]  ms_addr_lo,
  input  logic              data_rvalid,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              ws_valid,
  output logic [BYTE_W-1:0] rf_we,
  output logic [RF_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              ws_fwd_valid,
  output logic [RF_AW-1:0]  ws_fwd_waddr,
  output logic [DATA_W-1:0] ws_fwd_wdata,
  output logic              ws_load_pending,
  output logic [CNT_W-1:0]  retire_cnt
`ifdef WB_TRACE_EN
  ,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [BYTE_W-1:0] debug_wb_rf_we,
  output logic [RF_AW-1:0]  debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
`endif
);

  wb_state_e         state;
  wb_state_e         state_nxt;
  logic              ws_ready_go;
  logic              accept;
  logic              commit;
  logic              is_load_q;
  logic [2:0]        load_op_q;
  logic [OFS_W-1:0]  addr_lo_q;
  logic [BYTE_W-1:0] rf_we_q;
  logic [RF_AW-1:0]  rf_waddr_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] load_data;

  // The response is only consumed in WAIT, so a pulse in the accept cycle is never taken.
  assign ws_ready_go = !is_load_q || (state == WAIT && data_rvalid);
  assign ws_allow_in = !ws_valid || ws_ready_go;
  assign accept      = ms_to_ws_valid && ws_allow_in;
  assign commit      = ws_valid && ws_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (accept && ms_is_load) state_nxt = WAIT;
      WAIT:    if (data_rvalid) state_nxt = (accept && ms_is_load) ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: captured fields are reset too, so every output reads zero straight out of reset.
    if (!resetn) begin
      ws_valid   <= 1'b0;
      is_load_q  <= 1'b0;
      load_op_q  <= '0;
      addr_lo_q  <= '0;
      rf_we_q    <= '0;
      rf_waddr_q <= '0;
      result_q   <= '0;
    end else if (ws_allow_in) begin
      ws_valid <= ms_to_ws_valid;
      if (ms_to_ws_valid) begin
        is_load_q  <= ms_is_load;
        load_op_q  <= ms_load_op;
        addr_lo_q  <= ms_addr_lo;
        rf_we_q    <= ms_rf_we;
        rf_waddr_q <= ms_rf_waddr;
        result_q   <= ms_result;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     retire_cnt <= '0;
    else if (commit) retire_cnt <= retire_cnt + 1'b1;
  end

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata   (data_rdata),
    .addr_lo (addr_lo_q),
    .load_op (load_op_q),
    .data    (load_data)
  );

  assign rf_we           = commit ? rf_we_q : '0;
  assign rf_waddr        = rf_waddr_q;
  assign rf_wdata        = is_load_q ? load_data : result_q;
  assign ws_fwd_valid    = commit && (|rf_we_q);
  assign ws_fwd_waddr    = rf_waddr_q;
  assign ws_fwd_wdata    = rf_wdata;
  assign ws_load_pending = ws_valid && is_load_q && !ws_ready_go;

`ifdef WB_TRACE_EN
  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     pc_q <= '0;
    else if (accept) pc_q <= ms_pc;
  end

  assign debug_wb_pc       = commit ? pc_q : '0;
  assign debug_wb_rf_we    = rf_we;
  assign debug_wb_rf_wnum  = commit ? rf_waddr_q : '0;
  assign debug_wb_rf_wdata = commit ? rf_wdata : '0;
`else
  logic unused_pc;
  assign unused_pc = ^ms_pc;
`endif

endmodule

// File: tb/tb_wb_stage_gen.sv
// Self-checking bench for wb_stage_gen: directed sequences, load-align vector
// tables (32- and 64-bit instances) and a randomized run against a reference model.
module tb_wb_stage_gen;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        ms_to_ws_valid, ws_allow_in, ms_is_load, data_rvalid, ws_valid;
  logic [31:0] ms_pc, ms_result, data_rdata, rf_wdata, ws_fwd_wdata, retire_cnt;
  logic [3:0]  ms_rf_we, rf_we;
  logic [4:0]  ms_rf_waddr, rf_waddr, ws_fwd_waddr;
  logic [2:0]  ms_load_op;
  logic [1:0]  ms_addr_lo;
  logic        ws_fwd_valid, ws_load_pending;

  // 64-bit instance
  logic        w_ms_to_ws_valid, w_ws_allow_in, w_ms_is_load, w_data_rvalid, w_ws_valid;
  logic [31:0] w_ms_pc, w_retire_cnt;
  logic [63:0] w_ms_result, w_data_rdata, w_rf_wdata, w_ws_fwd_wdata;
  logic [7:0]  w_ms_rf_we, w_rf_we;
  logic [4:0]  w_ms_rf_waddr, w_rf_waddr, w_ws_fwd_waddr;
  logic [2:0]  w_ms_load_op, w_ms_addr_lo;
  logic        w_ws_fwd_valid, w_ws_load_pending;

`ifdef WB_TRACE_EN
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata, w_debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum, w_debug_wb_rf_wnum;
  logic [7:0]  w_debug_wb_rf_we;
  logic [63:0] w_debug_wb_rf_wdata;
`endif

  wb_stage_gen #(.DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid), .ws_allow_in(ws_allow_in),
    .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_result(ms_result),
    .ms_is_load(ms_is_load), .ms_load_op(ms_load_op), .ms_addr_lo(ms_addr_lo),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .ws_valid(ws_valid),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ws_fwd_valid(ws_fwd_valid),
    .ws_fwd_waddr(ws_fwd_waddr), .ws_fwd_wdata(ws_fwd_wdata),
    .ws_load_pending(ws_load_pending), .retire_cnt(retire_cnt)
`ifdef WB_TRACE_EN
    , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
  );

  wb_stage_gen #(.DATA_W(64)) dut64 (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(w_ms_to_ws_valid), .ws_allow_in(w_ws_allow_in),
    .ms_pc(w_ms_pc), .ms_rf_we(w_ms_rf_we), .ms_rf_waddr(w_ms_rf_waddr), .ms_result(w_ms_result),
    .ms_is_load(w_ms_is_load), .ms_load_op(w_ms_load_op), .ms_addr_lo(w_ms_addr_lo),
    .data_rvalid(w_data_rvalid), .data_rdata(w_data_rdata), .ws_valid(w_ws_valid),
    .rf_we(w_rf_we), .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata), .ws_fwd_valid(w_ws_fwd_valid),
    .ws_fwd_waddr(w_ws_fwd_waddr), .ws_fwd_wdata(w_ws_fwd_wdata),
    .ws_load_pending(w_ws_load_pending), .retire_cnt(w_retire_cnt)
`ifdef WB_TRACE_EN
    , .debug_wb_pc(w_debug_wb_pc), .debug_wb_rf_we(w_debug_wb_rf_we),
    .debug_wb_rf_wnum(w_debug_wb_rf_wnum), .debug_wb_rf_wdata(w_debug_wb_rf_wdata)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference load result from plain arithmetic on access size and signedness.
  function automatic logic [63:0] ref_load(input int op, input int lo, input logic [63:0] rd,
                                           input int dw);
    int nbytes;
    logic [63:0] v, span;
    bit sgn;
    case (op)
      0, 1:    nbytes = 1;
      2, 3:    nbytes = 2;
      4, 5:    nbytes = 4;
      default: nbytes = 8;
    endcase
    if (nbytes > dw / 8) nbytes = dw / 8;
    sgn = (op == 0) || (op == 2) || (op == 4) || (op == 5 && dw == 32);
    lo  = lo - (lo % nbytes);
    v   = rd >> (8 * lo);
    if (nbytes < 8) begin
      span = 64'd1 << (8 * nbytes);
      v    = v % span;
      if (sgn && v >= (span >> 1)) v = v - span;
    end
    if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic idle32();
    ms_to_ws_valid = 1'b0; ms_pc = '0; ms_rf_we = '0; ms_rf_waddr = '0; ms_result = '0;
    ms_is_load = 1'b0; ms_load_op = '0; ms_addr_lo = '0; data_rvalid = 1'b0; data_rdata = '0;
  endtask

  task automatic idle64();
    w_ms_to_ws_valid = 1'b0; w_ms_pc = '0; w_ms_rf_we = '0; w_ms_rf_waddr = '0;
    w_ms_result = '0; w_ms_is_load = 1'b0; w_ms_load_op = '0; w_ms_addr_lo = '0;
    w_data_rvalid = 1'b0; w_data_rdata = '0;
  endtask

  task automatic entry32(input logic ld, input logic [2:0] op, input logic [1:0] lo,
                         input logic [4:0] wa, input logic [31:0] res, input logic [31:0] pc);
    ms_to_ws_valid = 1'b1; ms_is_load = ld; ms_load_op = op; ms_addr_lo = lo;
    ms_rf_waddr = wa; ms_result = res; ms_rf_we = 4'hF; ms_pc = pc;
  endtask

  task automatic commit32(input string name, input logic [4:0] wa, input logic [31:0] data);
    check({name, " rf_we"}, 64'(rf_we), 64'hF);
    check({name, " rf_waddr"}, 64'(rf_waddr), 64'(wa));
    check({name, " rf_wdata"}, 64'(rf_wdata), 64'(data));
    check({name, " fwd_valid"}, 64'(ws_fwd_valid), 64'd1);
    check({name, " fwd_wdata"}, 64'(ws_fwd_wdata), 64'(data));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  lo;
    logic [63:0] rdata;
    logic [63:0] exp;
  } ld_vec_t;

  ld_vec_t v32[12];
  ld_vec_t v64[8];

  // Random-phase model state: the entry the stage is holding, as seen by the spec's rules.
  logic        m_valid, m_load, m_commit, exp_allow;
  logic [2:0]  m_op;
  logic [1:0]  m_lo;
  logic [4:0]  m_wa;
  logic [31:0] m_res, m_cnt, exp_data;
  logic [3:0]  m_we;
  logic [63:0] ref_val;
  int          exp_retire;

  initial begin
    v32[0]  = '{LB,  3'd3, 64'h80FF_FF00, 64'hFFFF_FF80};
    v32[1]  = '{LHU, 3'd2, 64'h8001_1234, 64'h0000_8001};
    v32[2]  = '{LH,  3'd2, 64'h8001_1234, 64'hFFFF_8001};
    v32[3]  = '{LBU, 3'd1, 64'h0000_AB00, 64'h0000_00AB};
    v32[4]  = '{LB,  3'd0, 64'h0000_007F, 64'h0000_007F};
    v32[5]  = '{LH,  3'd3, 64'h8001_1234, 64'hFFFF_8001};
    v32[6]  = '{LHU, 3'd1, 64'h1234_F678, 64'h0000_F678};
    v32[7]  = '{LW,  3'd3, 64'hCAFE_BABE, 64'hCAFE_BABE};
    v32[8]  = '{LWU, 3'd0, 64'h8000_0001, 64'h8000_0001};
    v32[9]  = '{LD,  3'd2, 64'h1122_3344, 64'h1122_3344};
    v32[10] = '{LBU, 3'd2, 64'h00FE_0000, 64'h0000_00FE};
    v32[11] = '{LH,  3'd0, 64'h0000_7FFF, 64'h0000_7FFF};

    v64[0] = '{LWU, 3'd4, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF};
    v64[1] = '{LW,  3'd4, 64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_DEAD_BEEF};
    v64[2] = '{LD,  3'd5, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    v64[3] = '{LB,  3'd7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80};
    v64[4] = '{LHU, 3'd6, 64'hABCD_0000_0000_0000, 64'h0000_0000_0000_ABCD};
    v64[5] = '{LH,  3'd7, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001};
    v64[6] = '{LBU, 3'd5, 64'h0000_FE00_0000_0000, 64'h0000_0000_0000_00FE};
    v64[7] = '{LW,  3'd0, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF};

    idle32();
    idle64();

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("reset allow_in", 64'(ws_allow_in), 64'd1);
    check("reset ws_valid", 64'(ws_valid), 64'd0);
    resetn = 1'b1;
    @(negedge clk); #1;
    check("reset allow_in post", 64'(ws_allow_in), 64'd1);
    check("reset rf_we", 64'(rf_we), 64'd0);
    check("reset rf_waddr", 64'(rf_waddr), 64'd0);
    check("reset rf_wdata", 64'(rf_wdata), 64'd0);
    check("reset fwd_valid", 64'(ws_fwd_valid), 64'd0);
    check("reset fwd_waddr", 64'(ws_fwd_waddr), 64'd0);
    check("reset fwd_wdata", 64'(ws_fwd_wdata), 64'd0);
    check("reset load_pending", 64'(ws_load_pending), 64'd0);
    check("reset retire_cnt", 64'(retire_cnt), 64'd0);
    check("reset64 allow_in", 64'(w_ws_allow_in), 64'd1);

    // ---- three back-to-back non-loads ----
    @(negedge clk); entry32(1'b0, 3'd0, 2'd0, 5'd1, 32'h11, 32'h100); #1;
    check("nl1 allow_in", 64'(ws_allow_in), 64'd1);
    @(negedge clk); entry32(1'b0, 3'd0, 2'd0, 5'd2, 32'h22, 32'h104); #1;
    commit32("nl1", 5'd1, 32'h11);
    check("nl2 allow_in", 64'(ws_allow_in), 64'd1);
    @(negedge clk); entry32(1'b0, 3'd0, 2'd0, 5'd3, 32'h33, 32'h108); #1;
    commit32("nl2", 5'd2, 32'h22);
    check("nl3 allow_in", 64'(ws_allow_in), 64'd1);
    @(negedge clk); idle32(); #1;
    commit32("nl3", 5'd3, 32'h33);
    @(negedge clk); #1;
    check("nl retire_cnt", 64'(retire_cnt), 64'd3);
    check("nl ws_valid", 64'(ws_valid), 64'd0);
    check("nl idle rf_we", 64'(rf_we), 64'd0);
    exp_retire = 3;

    // ---- LB with a 4-cycle response delay, upstream stalled behind it ----
    entry32(1'b1, LB, 2'd3, 5'd5, 32'h0, 32'h200); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); entry32(1'b0, 3'd0, 2'd0, 5'd9, 32'h99, 32'h204); #1;
      check($sformatf("lb wait%0d pending", i), 64'(ws_load_pending), 64'd1);
      check($sformatf("lb wait%0d allow_in", i), 64'(ws_allow_in), 64'd0);
      check($sformatf("lb wait%0d rf_we", i), 64'(rf_we), 64'd0);
    end
    @(negedge clk); data_rvalid = 1'b1; data_rdata = 32'h80FF_FF00; #1;
    commit32("lb", 5'd5, 32'hFFFF_FF80);
    check("lb pending clr", 64'(ws_load_pending), 64'd0);
    check("lb allow_in", 64'(ws_allow_in), 64'd1);
`ifdef WB_TRACE_EN
    check("lb debug_pc", 64'(debug_wb_pc), 64'h200);
    check("lb debug_wnum", 64'(debug_wb_rf_wnum), 64'd5);
`endif
    @(negedge clk); idle32(); #1;
    commit32("stalled nl", 5'd9, 32'h99);
    exp_retire += 2;

    // ---- load-align table through the 32-bit instance ----
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); entry32(1'b1, v32[i].op, v32[i].lo[1:0], 5'(i + 1), 32'h0, 32'(i)); #1;
      @(negedge clk); idle32(); data_rvalid = 1'b1; data_rdata = v32[i].rdata[31:0]; #1;
      check($sformatf("tbl32[%0d] rf_we", i), 64'(rf_we), 64'hF);
      check($sformatf("tbl32[%0d] rf_wdata", i), 64'(rf_wdata), v32[i].exp);
    end
    @(negedge clk); idle32(); #1;
    exp_retire += 12;
    check("tbl32 retire_cnt", 64'(retire_cnt), 64'(exp_retire));

    // ---- load commit overlapping the next load's accept; stray response in IDLE ----
    entry32(1'b1, LW, 2'd0, 5'd10, 32'h0, 32'h300); #1;
    @(negedge clk); entry32(1'b1, LBU, 2'd1, 5'd11, 32'h0, 32'h304);
    data_rvalid = 1'b1; data_rdata = 32'h1234_5678; #1;
    commit32("b2b A", 5'd10, 32'h1234_5678);
    check("b2b A allow_in", 64'(ws_allow_in), 64'd1);
    @(negedge clk); idle32(); #1;
    check("b2b B pending", 64'(ws_load_pending), 64'd1);
    check("b2b B no commit", 64'(rf_we), 64'd0);
    @(negedge clk); data_rvalid = 1'b1; data_rdata = 32'h0000_AB00; #1;
    commit32("b2b B", 5'd11, 32'h0000_00AB);
    @(negedge clk); idle32(); data_rvalid = 1'b1; data_rdata = 32'hFFFF_FFFF; #1;
    check("stray rf_we", 64'(rf_we), 64'd0);
    check("stray fwd_valid", 64'(ws_fwd_valid), 64'd0);
    check("stray ws_valid", 64'(ws_valid), 64'd0);
    @(negedge clk); idle32(); #1;
    exp_retire += 2;
    check("stray retire_cnt", 64'(retire_cnt), 64'(exp_retire));

    // ---- reset pulled mid-WAIT, then a late response ----
    entry32(1'b1, LW, 2'd0, 5'd12, 32'h0, 32'h400); #1;
    @(negedge clk); idle32(); #1;
    check("rst pre pending", 64'(ws_load_pending), 64'd1);
    #2 resetn = 1'b0; #1;
    check("rst ws_valid", 64'(ws_valid), 64'd0);
    check("rst retire_cnt", 64'(retire_cnt), 64'd0);
    check("rst allow_in", 64'(ws_allow_in), 64'd1);
    @(negedge clk); resetn = 1'b1; data_rvalid = 1'b1; data_rdata = 32'hAAAA_5555; #1;
    check("late rsp rf_we", 64'(rf_we), 64'd0);
    check("late rsp ws_valid", 64'(ws_valid), 64'd0);
    @(negedge clk); idle32(); #1;
    check("late rsp retire_cnt", 64'(retire_cnt), 64'd0);
    check("late rsp pending", 64'(ws_load_pending), 64'd0);

    // ---- load-align table through the 64-bit instance ----
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w_ms_to_ws_valid = 1'b1; w_ms_is_load = 1'b1; w_ms_load_op = v64[i].op;
      w_ms_addr_lo = v64[i].lo; w_ms_rf_waddr = 5'(i + 1); w_ms_rf_we = 8'hFF;
      w_ms_pc = 32'h1000 + 32'(i * 4); #1;
      @(negedge clk); idle64(); w_data_rvalid = 1'b1; w_data_rdata = v64[i].rdata; #1;
      check($sformatf("tbl64[%0d] rf_we", i), 64'(w_rf_we), 64'hFF);
      check($sformatf("tbl64[%0d] rf_wdata", i), w_rf_wdata, v64[i].exp);
`ifdef WB_TRACE_EN
      check($sformatf("tbl64[%0d] debug_pc", i), 64'(w_debug_wb_pc), 64'h1000 + 64'(i * 4));
`endif
    end
    @(negedge clk); idle64(); #1;
    check("tbl64 retire_cnt", 64'(w_retire_cnt), 64'd8);

    // ---- randomized run against the reference model (32-bit instance) ----
    m_valid = 1'b0; m_load = 1'b0; m_op = '0; m_lo = '0; m_wa = '0; m_res = '0; m_we = '0;
    m_cnt = 32'd0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      ms_to_ws_valid = ($urandom_range(0, 99) < 70);
      ms_is_load     = ($urandom_range(0, 2) == 0);
      ms_load_op     = 3'($urandom_range(0, 6));
      ms_addr_lo     = 2'($urandom);
      ms_rf_waddr    = 5'($urandom);
      ms_result      = $urandom;
      ms_rf_we       = 4'($urandom);
      ms_pc          = $urandom;
      data_rvalid    = ($urandom_range(0, 99) < 40);
      data_rdata     = $urandom;
      #1;
      m_commit  = m_valid && (!m_load || data_rvalid);
      exp_allow = !m_valid || m_commit;
      ref_val   = ref_load(int'(m_op), int'(m_lo), 64'(data_rdata), 32);
      exp_data  = m_load ? ref_val[31:0] : m_res;
      check("rnd allow_in", 64'(ws_allow_in), 64'(exp_allow));
      check("rnd ws_valid", 64'(ws_valid), 64'(m_valid));
      check("rnd rf_we", 64'(rf_we), m_commit ? 64'(m_we) : 64'd0);
      check("rnd fwd_valid", 64'(ws_fwd_valid), 64'(m_commit && (|m_we)));
      check("rnd load_pending", 64'(ws_load_pending), 64'(m_valid && m_load && !data_rvalid));
      check("rnd retire_cnt", 64'(retire_cnt), 64'(m_cnt));
      if (m_commit) begin
        check("rnd rf_waddr", 64'(rf_waddr), 64'(m_wa));
        check("rnd rf_wdata", 64'(rf_wdata), 64'(exp_data));
        check("rnd fwd_waddr", 64'(ws_fwd_waddr), 64'(m_wa));
        check("rnd fwd_wdata", 64'(ws_fwd_wdata), 64'(exp_data));
      end
      if (m_commit) m_cnt = m_cnt + 32'd1;
      if (exp_allow) begin
        m_valid = ms_to_ws_valid;
        if (ms_to_ws_valid) begin
          m_load = ms_is_load; m_op = ms_load_op; m_lo = ms_addr_lo;
          m_wa = ms_rf_waddr; m_res = ms_result; m_we = ms_rf_we;
        end
      end
    end
    @(negedge clk); idle32(); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
